// File: rtl/mac_pkg.sv
// Shared MAC TX/RX definitions: framer states, framing bytes, CRC-32 constants.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    PAY,
    PAD,
    FCS,
    DROP,
    IFG
  } mac_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef struct packed {
    logic [7:0] data;
    logic       eop;
    logic       err;
  } hold_t;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32 (reflected) register.
// clr reloads the init value; en folds one byte per cycle.
module crc32_d8
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  function automatic logic [31:0] crc_next(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ CRC_POLY_REFL;
      else      r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next(crc, data);
    end
  end

endmodule

// File: rtl/tx_frame_builder.sv
// Ethernet TX framer: preamble, SFD, payload, optional pad, FCS, IFG.
// Define TX_PAD_EN to zero-pad short frames up to MIN_FRAME.
module tx_frame_builder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int MIN_FRAME    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stream_in_startofpacket,
  input  logic                  stream_in_endofpacket,
  input  logic                  stream_in_valid,
  input  logic [DATA_WIDTH-1:0] stream_in_data,
  input  logic                  stream_in_error,
  output logic                  stream_in_ready,
  output logic                  stream_out_startofpacket,
  output logic                  stream_out_endofpacket,
  output logic                  stream_out_valid,
  output logic [DATA_WIDTH-1:0] stream_out_data,
  output logic                  stream_out_error,
  output logic                  frame_done,
  output logic                  underrun
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("tx_frame_builder: only DATA_WIDTH = 8 is supported");
  end
  if (MIN_FRAME < 6 || MIN_FRAME > 131) begin : g_bad_min
    $error("tx_frame_builder: MIN_FRAME out of range");
  end
  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 16) begin : g_bad_pre
    $error("tx_frame_builder: PREAMBLE_LEN out of range");
  end
  if (IFG_BYTES < 1 || IFG_BYTES > 256) begin : g_bad_ifg
    $error("tx_frame_builder: IFG_BYTES out of range");
  end

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  mac_state_t  state;
  mac_state_t  pay_next;
  hold_t       hold;
  logic        frame_err;
  logic [3:0]  pcnt;
  logic [7:0]  icnt;
  logic [1:0]  fcnt;
  logic [31:0] crc;
  logic        crc_clr;
  logic        crc_en;
  logic [7:0]  crc_din;
  logic [7:0]  fcs_raw;
  logic [7:0]  fcs_byte;
  logic        xfer;

  always_comb begin
    stream_in_ready = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:    stream_in_ready = 1'b1;
        PAY:     stream_in_ready = !hold.eop;
        DROP:    stream_in_ready = 1'b1;
        default: stream_in_ready = 1'b0;
      endcase
    end
  end

  assign xfer = stream_in_valid && stream_in_ready;

  assign crc_clr = (state == SFD);
  assign crc_en  = (state == PAY) || (state == PAD);
  assign crc_din = (state == PAD) ? 8'h00 : hold.data;

  crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (crc_din),
    .crc  (crc)
  );

  always_comb begin
    unique case (fcnt)
      2'd0:    fcs_raw = crc[7:0];
      2'd1:    fcs_raw = crc[15:8];
      2'd2:    fcs_raw = crc[23:16];
      default: fcs_raw = crc[31:24];
    endcase
  end

  // An errored frame keeps the raw CRC so the receiver is sure to reject it
  assign fcs_byte = frame_err ? fcs_raw : ~fcs_raw;

`ifdef TX_PAD_EN
  localparam logic [6:0] PAD_TARGET = 7'(MIN_FRAME - 4);

  logic [6:0] cnt;
  logic       pad_needed;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (crc_en && cnt != PAD_TARGET) begin
      cnt <= cnt + 7'd1;
    end
  end

  assign pad_needed = (cnt < PAD_TARGET - 7'd1);
  assign pay_next   = pad_needed ? PAD : FCS;
`else
  assign pay_next   = FCS;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      hold                     <= '0;
      frame_err                <= 1'b0;
      pcnt                     <= '0;
      icnt                     <= '0;
      fcnt                     <= '0;
      stream_out_valid         <= 1'b0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      stream_out_data          <= '0;
      stream_out_error         <= 1'b0;
      frame_done               <= 1'b0;
      underrun                 <= 1'b0;
    end else begin
      stream_out_valid         <= 1'b0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      stream_out_data          <= '0;
      stream_out_error         <= 1'b0;
      frame_done               <= 1'b0;
      underrun                 <= 1'b0;

      unique case (state)
        IDLE: begin
          // First preamble byte leaves with the capture so the IFG is exact
          if (xfer && stream_in_startofpacket) begin
            hold.data                <= stream_in_data;
            hold.eop                 <= stream_in_endofpacket;
            hold.err                 <= stream_in_error;
            frame_err                <= stream_in_error;
            stream_out_valid         <= 1'b1;
            stream_out_startofpacket <= 1'b1;
            stream_out_data          <= PREAMBLE_BYTE;
            pcnt                     <= 4'd1;
            state <= (PREAMBLE_LEN == 1) ? SFD : PRE;
          end
        end

        PRE: begin
          stream_out_valid <= 1'b1;
          stream_out_data  <= PREAMBLE_BYTE;
          pcnt             <= pcnt + 4'd1;
          if (pcnt == PRE_LAST) state <= SFD;
        end

        SFD: begin
          stream_out_valid <= 1'b1;
          stream_out_data  <= SFD_BYTE;
          fcnt             <= '0;
          state            <= PAY;
        end

        PAY: begin
          stream_out_valid <= 1'b1;
          stream_out_data  <= hold.data;
          stream_out_error <= hold.err;
          if (hold.eop) begin
            state <= pay_next;
          end else if (!stream_in_valid || stream_in_startofpacket) begin
            stream_out_error       <= 1'b1;
            stream_out_endofpacket <= 1'b1;
            underrun               <= 1'b1;
            icnt                   <= '0;
            if (stream_in_valid && stream_in_endofpacket) state <= IFG;
            else state <= DROP;
          end else begin
            hold.data <= stream_in_data;
            hold.eop  <= stream_in_endofpacket;
            hold.err  <= stream_in_error;
            frame_err <= frame_err | stream_in_error;
          end
        end

`ifdef TX_PAD_EN
        PAD: begin
          stream_out_valid <= 1'b1;
          stream_out_data  <= 8'h00;
          if (cnt == PAD_TARGET - 7'd1) state <= FCS;
        end
`endif

        FCS: begin
          stream_out_valid <= 1'b1;
          stream_out_data  <= fcs_byte;
          fcnt             <= fcnt + 2'd1;
          if (fcnt == 2'd3) begin
            stream_out_endofpacket <= 1'b1;
            frame_done             <= !frame_err;
            icnt                   <= '0;
            state                  <= IFG;
          end
        end

        DROP: begin
          if (xfer && stream_in_endofpacket) begin
            icnt  <= '0;
            state <= IFG;
          end
        end

        IFG: begin
          icnt <= icnt + 8'd1;
          if (icnt == IFG_LAST) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
